// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 device over the open-collector clock/data
// pair. It runs the request-to-send sequence: hold clock low, assert the start
// bit, release clock. It then shifts data LSB first, odd parity and stop on
// device-generated clock falling edges, and samples the device ACK.
//
// Optional build macro: PS2_TX_TIMEOUT_EN adds a watchdog. The watchdog aborts
// the frame when the device stops clocking for TIMEOUT_CYCLES cycles.
//
// Handshake: a byte is accepted in any cycle where tx_valid & tx_ready are both
// high. tx_ready is high only while the block is idle. A tx_valid seen while
// tx_ready is low is ignored, and the byte is not queued. Each accepted byte
// ends with exactly one single-cycle pulse on tx_done (ACK received) or on
// tx_err (NACK or timeout). tx_ready is already high in that pulse cycle.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before the start bit
//   TIMEOUT_CYCLES  max clk cycles between device clock falls (watchdog only)
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   ps2_clk_in   PS/2 clock pad level (asynchronous)
//   ps2_data_in  PS/2 data pad level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   tx_data      command byte
//   tx_valid     request to send tx_data
//   tx_ready     idle, byte accepted on tx_valid & tx_ready
//   tx_done      one-cycle pulse: frame sent and ACK received
//   tx_err       one-cycle pulse: NACK or timeout
//   fsm_state    debug view of the FSM state register
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] fsm_state
);

  // The inhibit counter runs 0 .. INHIBIT_CYCLES-1.
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_START   = 3'd2,
    S_SHIFT   = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             clk_oe_d, data_oe_d, ready_d, done_d, err_d;

  // Pad synchronizers. They reset to 1, which matches the idle (released)
  // bus level, so a spurious fall is not seen right after reset.
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Next-state and next-output logic. The outputs are registered from these
  // values, so the pads never see decode glitches.
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_d     = par_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          data_d    = tx_data;
          par_d     = ~^tx_data;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          // Start bit goes out while the clock is still held low.
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      S_START: begin
        // Release the clock. From now on the device owns the clock.
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        idx_d     = 4'd0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        if (fall) begin
          idx_d = idx_q + 4'd1;
          if (idx_q < 4'd8) begin
            data_oe_d = ~data_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;  // stop bit: line released
            state_d   = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (fall) begin
          if (!data_s2) begin
            state_d = S_RELEASE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_RELEASE: begin
        if (clk_s2 && data_s2) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // The watchdog is cleared in START (entry to SHIFT) and on every fall.
    // A frame that has already finished this cycle takes priority.
    if (state_q inside {S_SHIFT, S_ACK, S_RELEASE}) begin
      wd_d = fall ? '0 : wd_q + WD_W'(1);
      if (!fall && (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) && (state_d != S_IDLE)) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        err_d     = 1'b1;
        wd_d      = '0;
        state_d   = S_IDLE;
      end
    end
`endif

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      inh_cnt_q   <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      par_q       <= par_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_ready    <= ready_d;
      tx_done     <= done_d;
      tx_err      <= err_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign fsm_state = state_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same open-collector clock/data pair the terminal's keyboard receiver listens on. It runs the PS/2 request-to-send sequence, shifts out data, odd parity and stop on device-generated clock edges, and checks the device ACK. It sits beside the keyboard receiver; the top level ties each `*_oe` to a tri-state low driver on the pad.

## Interface
- `INHIBIT_CYCLES`, 5000: `clk` cycles the PS/2 clock is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum `clk` cycles between consecutive device clock falling edges (15 ms). Used only with `PS2_TX_TIMEOUT_EN`.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk_in`  in  1  PS/2 clock pad level (asynchronous).
- `ps2_data_in`  in  1  PS/2 data pad level (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive PS/2 clock low, 0 = release.
- `ps2_data_oe`  out  1  1 = drive PS/2 data low, 0 = release.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  block idle; accepts a byte when `tx_valid & tx_ready`.
- `tx_done`  out  1  one-cycle pulse: frame sent and ACK received.
- `tx_err`  out  1  one-cycle pulse: NACK, or timeout.

## Operation
- Both pad inputs pass through a 2-flop synchronizer. A third flop holds the previous synced clock level. `fall` = prev & ~sync.
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `tx_done`=0, `tx_err`=0. State is IDLE and all counters are 0.
- The byte is latched on `tx_valid & tx_ready`. Parity = ~^tx_data (odd).
- IDLE: `tx_ready`=1. On accept, go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1. Count INHIBIT_CYCLES cycles, then go to START.
- START: `ps2_data_oe`=1 (start bit 0) and `ps2_clk_oe` still 1 for exactly one cycle. Then release the clock and go to SHIFT with bit index 0.
- SHIFT: on each `fall`, `ps2_data_oe` = ~bit[idx]. Bits are sent in this order:
  - idx 0–7: d0..d7, LSB first
  - idx 8: parity
  - idx 9: stop; `ps2_data_oe`=0 (line released)
  - After idx 9, go to ACK.
- ACK: on the next `fall`, sample the synced data line. 0 goes to RELEASE; 1 pulses `tx_err` and returns to IDLE.
- RELEASE: wait until the synced clock and data are both 1. Then pulse `tx_done` and return to IDLE.
- Any `tx_valid` while `tx_ready`=0 is ignored. The byte is not queued.
- Asynchronous reset in any state immediately releases both lines and returns to IDLE. No `tx_err` is produced.

## Timing
- Accept edge to `ps2_clk_oe`=1: 1 cycle, registered.
- `ps2_clk_oe` stays high for INHIBIT_CYCLES+1 cycles; the last cycle overlaps `ps2_data_oe`=1.
- `fall` is detected 3 cycles after the pad edge. `ps2_data_oe` updates 1 cycle after `fall`, giving a 4-cycle total (80 ns). This is well within the device's low half-period.
- `tx_done`/`tx_err` are high for exactly one cycle; `tx_ready` returns to 1 in that same cycle.
- A new accept is possible in the cycle after `tx_done`/`tx_err`.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counter clears on entry to SHIFT and on every `fall`, and counts in SHIFT, ACK and RELEASE.
  - On reaching TIMEOUT_CYCLES, both lines are released, `tx_err` pulses and the state returns to IDLE.
- Not defined: no watchdog; the block waits indefinitely for device clocks. `tx_err` then signals NACK only.

## Test plan
- `tx_data`=0xED, device model clocks at 12.5 kHz and ACKs:
  - clock held low for 5000 cycles;
  - data bits sampled on rising edges read 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `tx_done` pulses once; `tx_err` stays 0.
- `tx_data`=0xF4, ACK: bits 0,0,1,0,1,1,1,1 LSB-first, parity 0, `tx_done` pulses. A second `tx_valid` held during the frame is not accepted until `tx_ready` returns.
- Device leaves data high on the 11th falling edge (NACK): `tx_err` pulses, `tx_done`=0, `tx_ready`=1 next cycle, both oe=0.
- With `PS2_TX_TIMEOUT_EN` and TIMEOUT_CYCLES=1000, device stops clocking after bit 3:
  - 1000 cycles after the last `fall`, both oe=0 and `tx_err` pulses;
  - without the macro, the block stays busy.
- Reset asserted (0) while idx=5: both oe=0 and `tx_ready`=1 immediately with no clock edge; after reset release, 0xFF sends normally.
- Back-to-back 0xED then 0x02, with `tx_valid` asserted in the `tx_done` cycle: the second frame starts INHIBIT 1 cycle later and completes with the correct bits and parity 0.
